// File: rtl/sse_multi_if.sv
// Sample/result bus of sse_multi: sample offer/accept, clear, result and error pulses.
interface sse_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_mode;
    logic             in_last;
    logic             clr;
    logic             res_valid;
    logic [CH_W-1:0]  res_ch;
    logic [31:0]      res_y;
    logic [CNT_W-1:0] res_cnt;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, in_ch, in_a, in_b, in_mode, in_last, clr,
        input  in_ready, res_valid, res_ch, res_y, res_cnt, err, busy
    );

    modport slave (
        input  in_valid, in_ch, in_a, in_b, in_mode, in_last, clr,
        output in_ready, res_valid, res_ch, res_y, res_cnt, err, busy
    );
endinterface

// File: rtl/sse_multi.sv
// Multi-channel fp32 sum of squared / absolute errors, built on one shared
// fp adder and one shared fp multiplier (start/ready handshaked units).

// fp32 adder/subtractor (op=1: a-b). Truncating rounding, denormal inputs
// read as zero, underflow flushes to zero. Latency LAT cycles, one extra
// when the operand exponents differ (alignment step).
module adder_fp #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ready,
    output logic        busy
);
    logic [7:0] tmr;

    function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] x, z;
        logic [27:0] mx, mz, m;
        logic [7:0]  d;
        int          lead, e;
        if (p[30:0] < q[30:0]) begin x = q; z = p; end
        else                   begin x = p; z = q; end
        if (x[30:23] == 8'hFF) begin
            if (z[30:23] == 8'hFF && x[22:0] == 23'd0 && z[22:0] == 23'd0 && x[31] != z[31])
                return 32'h7FC0_0000;
            return x;
        end
        if (x[30:23] == 8'd0) return 32'h0;
        mx = {2'b01, x[22:0], 3'b000};
        mz = (z[30:23] == 8'd0) ? 28'd0 : {2'b01, z[22:0], 3'b000};
        d  = x[30:23] - z[30:23];
        mz = (d > 8'd26) ? 28'd0 : (mz >> d);
        m  = (x[31] == z[31]) ? (mx + mz) : (mx - mz);
        if (m == 28'd0) return 32'h0;
        lead = 0;
        for (int i = 0; i < 28; i++) if (m[i]) lead = i;
        e = int'(x[30:23]) + lead - 26;
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        if (e <= 0)   return {x[31], 31'd0};
        m = (lead > 26) ? (m >> 1) : (m << (26 - lead));
        return {x[31], 8'(e), m[25:3]};
    endfunction

    assign ready = busy & (tmr == 8'd0);

    // Capture the result at start, then count down to the ready cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            tmr  <= 8'd0;
            y    <= 32'h0;
        end else if (start & ~busy) begin
            busy <= 1'b1;
            tmr  <= 8'(LAT - 1) + {7'd0, (a[30:23] != b[30:23])};
            y    <= fp_add(a, {b[31] ^ op, b[30:0]});
        end else if (busy) begin
            if (tmr == 8'd0) busy <= 1'b0;
            else             tmr  <= tmr - 8'd1;
        end
    end
endmodule

// fp32 multiplier, truncating rounding, denormals read as zero.
module multiplier_fp #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ready,
    output logic        busy
);
    logic [7:0] tmr;

    function automatic logic [31:0] fp_mul(input logic [31:0] p, input logic [31:0] q);
        logic        s;
        logic [47:0] m;
        int          e;
        s = p[31] ^ q[31];
        if (p[30:23] == 8'hFF || q[30:23] == 8'hFF) begin
            if ((p[30:23] == 8'hFF && p[22:0] != 23'd0) || (q[30:23] == 8'hFF && q[22:0] != 23'd0))
                return 32'h7FC0_0000;
            if (p[30:23] == 8'd0 || q[30:23] == 8'd0) return 32'h7FC0_0000;
            return {s, 8'hFF, 23'd0};
        end
        if (p[30:23] == 8'd0 || q[30:23] == 8'd0) return {s, 31'd0};
        m = {24'd0, 1'b1, p[22:0]} * {24'd0, 1'b1, q[22:0]};
        e = int'(p[30:23]) + int'(q[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), m[45:23]};
    endfunction

    assign ready = busy & (tmr == 8'd0);

    // Capture the product at start, then count down to the ready cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            tmr  <= 8'd0;
            y    <= 32'h0;
        end else if (start & ~busy) begin
            busy <= 1'b1;
            tmr  <= 8'(LAT - 1);
            y    <= fp_mul(a, b);
        end else if (busy) begin
            if (tmr == 8'd0) busy <= 1'b0;
            else             tmr  <= tmr - 8'd1;
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a sample; in_ready when both units are idle
// SUB   | adder computing a - b
// SQR   | multiplier squaring the difference (SSE only)
// ACC   | adder folding the term into the channel sum
// OUT   | presenting the finished channel result, clearing the channel
module sse_multi #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int CH_W    = 2,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    sse_multi_if.slave  bus
);
    localparam int NSLOT = 1 << CH_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUB  = 3'd1;
    localparam logic [2:0] S_SQR  = 3'd2;
    localparam logic [2:0] S_ACC  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       state;
    logic [31:0]      a_r, b_r, term_r;
    logic [CH_W-1:0]  ch_r;
    logic             mode_r, last_r;
    logic [31:0]      acc [NSLOT];
    logic [CNT_W-1:0] cnt [NSLOT];
    logic [CNT_W-1:0] cnt_inc;

    logic             add_start, add_ready, add_busy;
    logic             mul_start, mul_ready, mul_busy;
    logic [31:0]      add_a, add_b, add_y, mul_y;
    logic             accept, ch_ok;

    assign bus.in_ready = (state == S_IDLE) & ~rst & ~bus.clr & ~add_busy & ~mul_busy;
    assign bus.busy     = (state != S_IDLE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign ch_ok        = {1'b0, bus.in_ch} < (CH_W + 1)'(NCH);

    // The adder is shared: SUB forms a - b, ACC forms term + acc[ch].
    assign add_a   = (state == S_ACC) ? term_r : a_r;
    assign add_b   = (state == S_ACC) ? acc[ch_r] : b_r;
    assign cnt_inc = (&cnt[ch_r]) ? cnt[ch_r] : cnt[ch_r] + 1'b1;

    adder_fp #(.LAT(ADD_LAT)) u_add (
        .clk(clk), .rst(rst), .start(add_start), .op(state == S_SUB),
        .a(add_a), .b(add_b), .y(add_y), .ready(add_ready), .busy(add_busy)
    );

    multiplier_fp #(.LAT(MUL_LAT)) u_mul (
        .clk(clk), .rst(rst), .start(mul_start),
        .a(term_r), .b(term_r), .y(mul_y), .ready(mul_ready), .busy(mul_busy)
    );

    // Sequencer: one sample at a time; clr aborts, and a unit still busy from
    // an aborted sample just finishes unobserved while in_ready stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            a_r           <= 32'h0;
            b_r           <= 32'h0;
            term_r        <= 32'h0;
            ch_r          <= '0;
            mode_r        <= 1'b0;
            last_r        <= 1'b0;
            add_start     <= 1'b0;
            mul_start     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_y     <= 32'h0;
            bus.res_cnt   <= '0;
            bus.err       <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                acc[i] <= 32'h0;
                cnt[i] <= '0;
            end
        end else begin
            add_start     <= 1'b0;
            mul_start     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.err       <= 1'b0;
            if (bus.clr) begin
                state <= S_IDLE;
                for (int i = 0; i < NSLOT; i++) begin
                    acc[i] <= 32'h0;
                    cnt[i] <= '0;
                end
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        if (ch_ok) begin
                            a_r       <= bus.in_a;
                            b_r       <= bus.in_b;
                            ch_r      <= bus.in_ch;
                            mode_r    <= bus.in_mode;
                            last_r    <= bus.in_last;
                            add_start <= 1'b1;
                            state     <= S_SUB;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                    S_SUB: if (add_ready) begin
                        if (mode_r) begin
                            term_r    <= {1'b0, add_y[30:0]};
                            add_start <= 1'b1;
                            state     <= S_ACC;
                        end else begin
                            term_r    <= add_y;
                            mul_start <= 1'b1;
                            state     <= S_SQR;
                        end
                    end
                    S_SQR: if (mul_ready) begin
                        term_r    <= mul_y;
                        add_start <= 1'b1;
                        state     <= S_ACC;
                    end
                    S_ACC: if (add_ready) begin
                        acc[ch_r] <= add_y;
                        cnt[ch_r] <= cnt_inc;
                        state     <= last_r ? S_OUT : S_IDLE;
                    end
                    S_OUT: begin
                        bus.res_valid <= 1'b1;
                        bus.res_ch    <= ch_r;
                        bus.res_y     <= acc[ch_r];
                        bus.res_cnt   <= cnt[ch_r];
                        acc[ch_r]     <= 32'h0;
                        cnt[ch_r]     <= '0;
                        state         <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
